// File: rtl/j6502_bus_ctrl.sv
// rtl/j6502_bus_ctrl.sv - J6502 phi1/phi2 generator, chip-select decode and read capture
// Optional phi2 wait-state stretching is enabled by defining J6502_BUS_CTRL_STRETCH_EN.
`timescale 1ns/1ps
module j6502_bus_ctrl #(
    parameter int PHASE_LEN = 4,
    parameter int ROM_WAIT  = 1,
    parameter int IO_WAIT   = 0
) (
    input  logic        fst_clk,
    input  logic        res,
    input  logic [15:0] address,
    input  logic        rw_n,
    input  logic [7:0]  ram_din,
    input  logic [7:0]  via_din,
    input  logic [7:0]  rom_din,
    output logic        phi1,
    output logic        phi2,
    output logic        cs_ram,
    output logic        cs_via,
    output logic        cs_rom,
    output logic        we_n,
    output logic [7:0]  cpu_din
);

    typedef enum logic [1:0] {PH1, GAP1, PH2, GAP2} state_t;
    typedef enum logic [1:0] {SEL_RAM, SEL_VIA, SEL_ROM} sel_t;

    localparam logic [3:0] LAST = 4'(PHASE_LEN - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       rd;
    sel_t       sel;
    sel_t       dec_sel;
    logic [7:0] sel_data;
    logic       ph2_done;

    // Only bits [15:13] take part in the decode; the VIA sees its own low bits.
    logic unused_addr;
    assign unused_addr = ^address[12:0];

    always_comb begin
        dec_sel = SEL_RAM;
        if (address[15])
            dec_sel = SEL_ROM;
        else if (address[14:13] == 2'b11)
            dec_sel = SEL_VIA;
    end

    always_comb begin
        sel_data = ram_din;
        case (sel)
            SEL_VIA: sel_data = via_din;
            SEL_ROM: sel_data = rom_din;
            default: sel_data = ram_din;
        endcase
    end

`ifdef J6502_BUS_CTRL_STRETCH_EN
    logic [2:0] stretch;
    logic [2:0] wait_len;
    logic [2:0] dec_wait;

    always_comb begin
        dec_wait = 3'd0;
        case (dec_sel)
            SEL_ROM: dec_wait = 3'(ROM_WAIT);
            SEL_VIA: dec_wait = 3'(IO_WAIT);
            default: dec_wait = 3'd0;
        endcase
    end

    assign ph2_done = (cnt == LAST) && (stretch == wait_len);

    always_ff @(posedge fst_clk) begin
        if (res) begin
            stretch  <= 3'd0;
            wait_len <= 3'd0;
        end else if (state == GAP1) begin
            stretch  <= 3'd0;
            wait_len <= dec_wait;
        end else if (state == PH2 && cnt == LAST && !ph2_done) begin
            stretch <= stretch + 3'd1;
        end
    end
`else
    assign ph2_done = (cnt == LAST);
`endif

    // cnt counts the cycles already spent in the current phase; reset leaves it
    // at 0 so the first edge out of reset raises phi1 as PH1's first cycle.
    always_ff @(posedge fst_clk) begin
        if (res) begin
            state   <= PH1;
            cnt     <= 4'd0;
            phi1    <= 1'b0;
            phi2    <= 1'b0;
            cs_ram  <= 1'b0;
            cs_via  <= 1'b0;
            cs_rom  <= 1'b0;
            we_n    <= 1'b1;
            cpu_din <= 8'h00;
            rd      <= 1'b1;
            sel     <= SEL_RAM;
        end else begin
            case (state)
                PH1: begin
                    if (cnt == LAST) begin
                        state <= GAP1;
                        cnt   <= 4'd0;
                        phi1  <= 1'b0;
                    end else begin
                        cnt  <= cnt + 4'd1;
                        phi1 <= 1'b1;
                    end
                end
                GAP1: begin
                    state  <= PH2;
                    cnt    <= 4'd1;
                    phi2   <= 1'b1;
                    rd     <= rw_n;
                    sel    <= dec_sel;
                    cs_ram <= (dec_sel == SEL_RAM);
                    cs_via <= (dec_sel == SEL_VIA);
                    cs_rom <= (dec_sel == SEL_ROM);
                    we_n   <= rw_n;
                end
                PH2: begin
                    if (ph2_done) begin
                        state  <= GAP2;
                        cnt    <= 4'd0;
                        phi2   <= 1'b0;
                        cs_ram <= 1'b0;
                        cs_via <= 1'b0;
                        cs_rom <= 1'b0;
                        we_n   <= 1'b1;
                        if (rd)
                            cpu_din <= sel_data;
                    end else if (cnt == LAST) begin
                        // each wait state adds a full PHASE_LEN of phi2 high time
                        cnt <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= PH1;
                    cnt   <= 4'd1;
                    phi1  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_j6502_bus_ctrl.sv
// tb/tb_j6502_bus_ctrl.sv - directed scoreboard bench for j6502_bus_ctrl
`timescale 1ns/1ps
module tb_j6502_bus_ctrl;

    localparam int PL = 4;
    localparam int RW_ROM = 1;
    localparam int RW_IO = 0;
`ifdef J6502_BUS_CTRL_STRETCH_EN
    localparam int EFF_ROM = RW_ROM;
    localparam int EFF_IO  = RW_IO;
`else
    localparam int EFF_ROM = 0;
    localparam int EFF_IO  = 0;
`endif
    localparam int PH2_NORM = PL - 1;
    localparam int PH2_ROM  = PL - 1 + EFF_ROM * PL;
    localparam int PH2_IO   = PL - 1 + EFF_IO * PL;

    logic        fst_clk = 1'b0;
    logic        res = 1'b1;
    logic [15:0] address = 16'h0000;
    logic        rw_n = 1'b1;
    logic [7:0]  ram_din = 8'h00;
    logic [7:0]  via_din = 8'h00;
    logic [7:0]  rom_din = 8'h00;
    logic        phi1, phi2, cs_ram, cs_via, cs_rom, we_n;
    logic [7:0]  cpu_din;

    int nvec = 0;
    int nfail = 0;
    logic [7:0] sb[$];

    j6502_bus_ctrl #(.PHASE_LEN(PL), .ROM_WAIT(RW_ROM), .IO_WAIT(RW_IO)) dut (
        .fst_clk(fst_clk), .res(res), .address(address), .rw_n(rw_n),
        .ram_din(ram_din), .via_din(via_din), .rom_din(rom_din),
        .phi1(phi1), .phi2(phi2), .cs_ram(cs_ram), .cs_via(cs_via), .cs_rom(cs_rom),
        .we_n(we_n), .cpu_din(cpu_din)
    );

    always #5 fst_clk = ~fst_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Precondition: the next rising edge starts PH1. Returns at the GAP2 sample.
    task automatic bus_cycle(input logic [15:0] addr, input logic rw, input logic [15:0] mid_addr,
                             input logic [2:0] exp_cs, input logic [7:0] exp_din, input int exp_ph2);
        int n_ph1 = 0;
        int n_ph2 = 0;
        int n = 0;
        logic prev2 = 1'b0;
        bit done = 0;
        logic [7:0] exp_q;
        address = addr;
        rw_n = rw;
        sb.push_back(exp_din);
        while (!done && n < 64) begin
            @(negedge fst_clk);
            n++;
            if (n == 1) chk("phi1_rise", 8'(phi1), 8'd1);
            chk("overlap", 8'(phi1 & phi2), 8'd0);
            chk("cs", 8'({cs_rom, cs_via, cs_ram}), 8'(phi2 ? exp_cs : 3'b000));
            chk("we_n", 8'(we_n), 8'(phi2 ? rw : 1'b1));
            if (phi1) n_ph1++;
            if (phi2) begin
                n_ph2++;
                address = mid_addr;
            end
            if (prev2 && !phi2) done = 1;
            prev2 = phi2;
        end
        if (!done) chk("timeout", 8'd0, 8'd1);
        exp_q = sb.pop_front();
        chk("cpu_din", cpu_din, exp_q);
        chk("ph1_len", 8'(n_ph1), 8'(PL - 1));
        chk("ph2_len", 8'(n_ph2), 8'(exp_ph2));
        chk("period", 8'(n), 8'(PL + exp_ph2 + 1));
    endtask

    initial begin
        int n;
        int n2;
        logic [7:0] exp_q;
        res = 1'b1;
        address = 16'h1234;
        rw_n = 1'b1;
        ram_din = 8'hA5;
        via_din = 8'h3C;
        rom_din = 8'h5A;
        repeat (3) @(negedge fst_clk);
        chk("rst_phi1", 8'(phi1), 8'd0);
        chk("rst_phi2", 8'(phi2), 8'd0);
        chk("rst_cs", 8'({cs_rom, cs_via, cs_ram}), 8'd0);
        chk("rst_we_n", 8'(we_n), 8'd1);
        chk("rst_cpu_din", cpu_din, 8'h00);
        res = 1'b0;

        bus_cycle(16'h1234, 1'b1, 16'h1234, 3'b001, 8'hA5, PH2_NORM);
        bus_cycle(16'h6003, 1'b0, 16'h6003, 3'b010, 8'hA5, PH2_IO);
        bus_cycle(16'h6013, 1'b1, 16'h6013, 3'b010, 8'h3C, PH2_IO);
        ram_din = 8'h11;
        bus_cycle(16'h5FFF, 1'b1, 16'h5FFF, 3'b001, 8'h11, PH2_NORM);
        bus_cycle(16'hFFFC, 1'b1, 16'hFFFC, 3'b100, 8'h5A, PH2_ROM);
        rom_din = 8'h77;
        bus_cycle(16'h8000, 1'b1, 16'h0000, 3'b100, 8'h77, PH2_ROM);
        bus_cycle(16'h7FFF, 1'b0, 16'h7FFF, 3'b010, 8'h77, PH2_IO);

        // Reset in the middle of a ROM write strobe.
        address = 16'h8000;
        rw_n = 1'b0;
        n = 0;
        n2 = 0;
        while (n2 < 2 && n < 40) begin
            @(negedge fst_clk);
            n++;
            if (phi2) n2++;
        end
        chk("pre_rst_cs_rom", 8'(cs_rom), 8'd1);
        chk("pre_rst_we_n", 8'(we_n), 8'd0);
        res = 1'b1;
        @(negedge fst_clk);
        chk("mid_rst_phi1", 8'(phi1), 8'd0);
        chk("mid_rst_phi2", 8'(phi2), 8'd0);
        chk("mid_rst_cs_rom", 8'(cs_rom), 8'd0);
        chk("mid_rst_we_n", 8'(we_n), 8'd1);
        chk("mid_rst_cpu_din", cpu_din, 8'h00);
        @(negedge fst_clk);
        chk("hold_rst_phi1", 8'(phi1), 8'd0);
        res = 1'b0;
        ram_din = 8'hA5;
        bus_cycle(16'h1234, 1'b1, 16'h1234, 3'b001, 8'hA5, PH2_NORM);

        if (sb.size() != 0) begin
            exp_q = 8'(sb.size());
            chk("sb_empty", exp_q, 8'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/j6502_bus_ctrl.md
# j6502_bus_ctrl

Bus-cycle controller for the J6502 system. It derives the two-phase non-overlapping phi1/phi2 clocks from `fst_clk` and decodes the CPU address into RAM/VIA/ROM chip selects. It generates write strobes and captures read data for the CPU. It sits between `CPU_6502`, the VIA and the memories. Optionally, it stretches phi2 to add wait states for slow regions.

## Interface
Parameters:
- `PHASE_LEN`, 4: `fst_clk` cycles per half bus cycle; legal range 2..16.
- `ROM_WAIT`, 1: extra phi2 stretch for ROM accesses, in units of `PHASE_LEN` cycles; range 0..7.
- `IO_WAIT`, 0: extra phi2 stretch for VIA-region accesses; same units and range as `ROM_WAIT`.

Ports:
- `fst_clk` in 1: the only clock.
- `res` in 1: synchronous, active-high reset.
- `address` in 16: CPU address bus.
- `rw_n` in 1: CPU read/write; 1 = read.
- `ram_din` in 8: RAM read data.
- `via_din` in 8: VIA read data.
- `rom_din` in 8: ROM read data.
- `phi1` out 1: phase-1 clock, registered.
- `phi2` out 1: phase-2 clock, registered; feeds the CPU `phi` input.
- `cs_ram` out 1: RAM select, active high.
- `cs_via` out 1: VIA select, active high.
- `cs_rom` out 1: ROM select, active high.
- `we_n` out 1: write strobe, active low.
- `cpu_din` out 8: registered read data to the CPU.

## Operation
- Memory map, decoded from address bits [15:13]:
  - 0x0000–0x5FFF selects RAM.
  - 0x6000–0x7FFF selects the VIA. The VIA uses `address[3:0]`, so it is mirrored every 16 bytes.
  - 0x8000–0xFFFF selects ROM.
- Every address maps to exactly one device; there is no unmapped space.
- The state machine has four states, stepped by a 4-bit phase counter `cnt`:
  - PH1: phi1 is high for `PHASE_LEN-1` cycles, then → GAP1.
  - GAP1: 1 cycle, both phases low. On exit, `address` and `rw_n` are latched and decoded. → PH2.
  - PH2: phi2 is high for `PHASE_LEN-1 + W*PHASE_LEN` cycles, where W is `ROM_WAIT`, `IO_WAIT` or 0, chosen by the decoded region. A 3-bit stretch counter counts the W extensions. → GAP2.
  - GAP2: 1 cycle, both phases low. → PH1.
- phi1 and phi2 are never high in the same cycle. Each gap guarantees at least one low cycle between the phases.
- Chip select and write strobe:
  - The decoded `cs_*` asserts on the same edge phi2 rises and deasserts on the same edge phi2 falls.
  - `we_n` goes low together with `cs_*` only when the latched `rw_n` is 0.
- Read capture:
  - On the edge that ends PH2 (the phi2 fall), and only if the latched `rw_n` is 1, `cpu_din` loads the selected device's data.
  - It then holds until the next read capture.
  - Write cycles leave `cpu_din` unchanged.
- Address changes during PH2 have no effect; the decode uses the values latched at GAP1 exit.
- Reset:
  - While `res` is high: state is PH1, `cnt` = 0, stretch counter = 0.
  - Reset values: `phi1`=0, `phi2`=0, all `cs_*`=0, `we_n`=1, `cpu_din`=8'h00.
  - Reset asserted mid-cycle, including mid-stretch, forces these values on the next edge. No partial write strobe survives.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- First edge with `res` low: `phi1` goes high.
- Unstretched period is `2*PHASE_LEN` cycles. For `PHASE_LEN`=4, cycles are numbered from the first phi1-high cycle:
  - phi1 high in cycles 0–2; GAP1 is cycle 3.
  - phi2 high in cycles 4–6; GAP2 is cycle 7.
  - Next phi1 rises at cycle 8.
- A stretched access has period `2*PHASE_LEN + W*PHASE_LEN` cycles. ROM with W=1 and `PHASE_LEN`=4 gives 12 cycles, with phi2 high for 7.
- Read latency: `cpu_din` is valid in the GAP2 cycle, one cycle before the next phi1 rise.
- Device data must be stable during the last phi2-high cycle.

## Configuration
- Macro: `J6502_BUS_CTRL_STRETCH_EN`.
- Defined: phi2 stretching is active as described above.
- Undefined:
  - The stretch counter and stretch logic are compiled out.
  - `ROM_WAIT` and `IO_WAIT` are ignored.
  - Every cycle is `2*PHASE_LEN` long regardless of region.

## Test plan
- Reset then release, `PHASE_LEN`=4 → phi1 high in cycles 0–2, phi2 high in cycles 4–6, period 8; phi1 and phi2 never both high over 100 cycles.
- Read 0x1234, `ram_din`=8'hA5 → `cs_ram` high only during phi2; `we_n` stays 1; `cpu_din`=8'hA5 from the phi2 fall.
- Write 0x6003 (`rw_n`=0) → `cs_via` and `we_n`=0 coincide exactly with phi2 high; `cpu_din` unchanged.
- Read 0xFFFC, `ROM_WAIT`=1, macro defined → phi2 high 7 cycles, period 12, `cpu_din`=`rom_din`. With macro undefined → period 8.
- Change `address` from 0x8000 to 0x0000 mid-PH2 → `cs_rom` stays selected until the phi2 fall; `cs_ram` never pulses.
- Assert `res` during a stretched ROM write → next edge: `phi2`=0, `cs_rom`=0, `we_n`=1, `cpu_din`=8'h00. After release, the normal sequence restarts at PH1.
